// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled start-bit hunt, mid-bit sampling, parity and
// stop-bit checks, and a valid/ack result register with per-character error flags.
module uart_receiver (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       busy_o,
  output logic [2:0] dbg_state
);

  // Handshake: rx_valid_o rises when a character is loaded and stays high until a
  // cycle with rx_ack_i = 1; a completion in that same cycle reloads instead of clearing.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       rx_meta;
  logic       rxs;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic       par_err_q;
  logic       stop_err_q;
  logic [1:0] width_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic       stop2_q;

  logic       tick;
  logic       sample;
  logic       start_ok;
  logic       last_bit;
  logic       done;
  logic       frame_err_now;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && !rxs) state_d = S_START;
      S_START:  if (tick && cnt == 4'd7) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (sample && last_bit) state_d = par_en_q ? S_PARITY : S_STOP1;
      end
      S_PARITY: if (sample) state_d = S_STOP1;
      S_STOP1: begin
        if (sample) begin
          if (stop2_q)                     state_d = S_STOP2;
          else if (frame_err_now && !rxs)  state_d = S_BREAK;
          else                             state_d = S_IDLE;
        end
      end
      S_STOP2: begin
        if (sample) state_d = (frame_err_now && !rxs) ? S_BREAK : S_IDLE;
      end
      S_BREAK:  if (rxs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick          = ov_baud_rt_i;
    sample        = tick && (cnt == 4'd15);
    start_ok      = (state_q == S_START) && tick && (cnt == 4'd7) && !rxs;
    last_bit      = (bit_idx == (3'd4 + {1'b0, width_q}));
    frame_err_now = stop_err_q | ~rxs;
    done          = sample && (((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2));
    dbg_state     = state_q;
  end

  // The counter runs freely and is re-zeroed at the start edge and at start-bit mid-point,
  // so every later sample lands on its natural 15->0 wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= 4'd0;
    end else if ((state_q == S_IDLE) && tick && !rxs) begin
      cnt <= 4'd0;
    end else if (start_ok) begin
      cnt <= 4'd0;
    end else if (tick) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_idx    <= 3'd0;
      data_q     <= 8'h00;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      width_q    <= 2'd0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (start_ok) begin
      bit_idx    <= 3'd0;
      data_q     <= 8'h00;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      width_q    <= data_width_i;
      par_en_q   <= parity_en_i;
      par_odd_q  <= parity_odd_i;
      stop2_q    <= stop_bits_i;
    end else if (sample) begin
      case (state_q)
        S_DATA: begin
          data_q[bit_idx] <= rxs;
          bit_idx         <= bit_idx + 3'd1;
        end
        S_PARITY: par_err_q  <= ((^data_q) ^ rxs) != par_odd_q;
        S_STOP1:  stop_err_q <= ~rxs;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      busy_o <= (state_d != S_IDLE);
      if (done && (!rx_valid_o || rx_ack_i)) begin
        rx_data_o    <= data_q;
        parity_err_o <= par_err_q & par_en_q;
        frame_err_o  <= frame_err_now;
        rx_valid_o   <= 1'b1;
        if (rx_valid_o) overrun_err_o <= 1'b0;
      end else if (done) begin
        overrun_err_o <= 1'b1;
      end else if (rx_ack_i && rx_valid_o) begin
        rx_valid_o    <= 1'b0;
        overrun_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a 16x tick every 4 clocks and hand-built serial frames.
module tb_uart_receiver;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP1 = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd6;

  logic       clk_i;
  logic       rst_i;
  logic       ov_baud_rt_i;
  logic       rx_i;
  logic [1:0] data_width_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       stop_bits_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ack_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;
  logic       busy_o;
  logic [2:0] dbg_state;

  int checks;
  int failures;
  int div;

  uart_receiver dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ov_baud_rt_i  (ov_baud_rt_i),
    .rx_i          (rx_i),
    .data_width_i  (data_width_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop_bits_i   (stop_bits_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ack_i      (rx_ack_i),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .busy_o        (busy_o),
    .dbg_state     (dbg_state)
  );

  // clock / reset and tick generation
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    div          = 0;
    ov_baud_rt_i = 1'b0;
  end

  always @(negedge clk_i) begin
    div          = (div + 1) % 4;
    ov_baud_rt_i = (div == 3);
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk_i);
      if (ov_baud_rt_i) k++;
    end
  endtask

  task automatic set_fmt(input logic [1:0] w, input logic pe, input logic po, input logic sb);
    @(negedge clk_i);
    data_width_i = w;
    parity_en_i  = pe;
    parity_odd_i = po;
    stop_bits_i  = sb;
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int nd, input logic has_par,
                                             input logic par, input logic s1, input logic has_s2,
                                             input logic s2);
    logic [15:0] f;
    int p;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1+i] = d[i];
    p = 1 + nd;
    if (has_par) begin
      f[p] = par;
      p++;
    end
    f[p] = s1;
    p++;
    if (has_s2) f[p] = s2;
    return f;
  endfunction

  task automatic send_bits(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      rx_i = f[i];
      wait_ticks(16);
    end
  endtask

  task automatic send_8n1(input logic [7:0] d);
    send_bits(frame_bits(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 10);
  endtask

  task automatic do_ack();
    @(negedge clk_i);
    rx_ack_i = 1'b1;
    @(negedge clk_i);
    rx_ack_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int c;
    c = 0;
    while (dbg_state !== s && c < budget) begin
      @(negedge clk_i);
      c++;
    end
    checks++;
    if (dbg_state !== s) begin
      failures++;
      $display("FAIL %s: state=%0d required=%0d (timeout)", name, dbg_state, s);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_i = 1'b1;
    rx_i = 1'b1;
    rx_ack_i = 1'b0;
    data_width_i = 2'd3;
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
    stop_bits_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h v=%b pe=%b fe=%b ov=%b busy=%b required all 0",
               rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: state=%0d required=%0d", dbg_state, ST_IDLE);
    end
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_8n1();
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    send_8n1(8'hA5);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'hA5 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 5'b10000) begin
      failures++;
      $display("FAIL 8n1_a5: data=%h flags=%b required data=a5 flags=10000", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o});
    end
    repeat (100) @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'hA5 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b1000) begin
      failures++;
      $display("FAIL 8n1_hold: data=%h flags=%b required data=a5 flags=1000", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o});
    end
    rx_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (rx_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL 8n1_ack: valid=%b required=0", rx_valid_o);
    end
    @(negedge clk_i);
    rx_ack_i = 1'b0;
  endtask

  task automatic test_parity();
    set_fmt(2'd2, 1'b1, 1'b0, 1'b0);
    send_bits(frame_bits(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 10);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h41 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b1100) begin
      failures++;
      $display("FAIL 7e1_bad_parity: data=%h flags=%b required data=41 flags=1100", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o});
    end
    do_ack();
    send_bits(frame_bits(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 10);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h41 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b1000) begin
      failures++;
      $display("FAIL 7e1_good_parity: data=%h flags=%b required data=41 flags=1000", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o});
    end
    do_ack();
  endtask

  task automatic test_break();
    set_fmt(2'd0, 1'b1, 1'b1, 1'b1);
    // 0x15 has three ones, so odd parity bit is 0; second stop bit driven low
    send_bits(frame_bits(8'h15, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 9);
    wait_ticks(40);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h15 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 5'b10101) begin
      failures++;
      $display("FAIL 5o2_frame_err: data=%h flags=%b required data=15 flags=10101", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o});
    end
    checks++;
    if (dbg_state !== ST_BREAK) begin
      failures++;
      $display("FAIL 5o2_break_wait: state=%0d required=%0d", dbg_state, ST_BREAK);
    end
    do_ack();
    wait_ticks(20);
    @(negedge clk_i);
    checks++;
    if (dbg_state !== ST_BREAK || rx_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL break_no_frame: state=%0d valid=%b required state=%0d valid=0", dbg_state,
               rx_valid_o, ST_BREAK);
    end
    rx_i = 1'b1;
    wait_state(ST_IDLE, 20, "break_release");
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL break_busy: busy=%b required=0", busy_o);
    end
  endtask

  task automatic test_glitch();
    set_fmt(2'd3, 1'b0, 1'b0, 1'b0);
    rx_i = 1'b0;
    wait_ticks(6);
    @(negedge clk_i);
    checks++;
    if (dbg_state !== ST_START || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL glitch_start: state=%0d busy=%b required state=%0d busy=1", dbg_state, busy_o,
               ST_START);
    end
    rx_i = 1'b1;
    wait_ticks(16);
    @(negedge clk_i);
    checks++;
    if (dbg_state !== ST_IDLE || busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: state=%0d busy=%b valid=%b required state=0 busy=0 valid=0",
               dbg_state, busy_o, rx_valid_o);
    end
    send_8n1(8'h3C);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h3C || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b1000) begin
      failures++;
      $display("FAIL glitch_then_3c: data=%h flags=%b required data=3c flags=1000", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o});
    end
  endtask

  task automatic test_reset_midframe();
    // 0x3C is still held; start a frame of 0x96 and reset during data bit 3
    send_bits(frame_bits(8'h96, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 4);
    @(negedge clk_i);
    rx_i = 1'b0;
    wait_ticks(8);
    @(negedge clk_i);
    checks++;
    if (dbg_state !== ST_DATA || rx_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: state=%0d valid=%b required state=%0d valid=1", dbg_state,
               rx_valid_o, ST_DATA);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 13'h0 ||
        dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL async_reset: data=%h flags=%b state=%0d required all 0", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o}, dbg_state);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    rx_i = 1'b1;
    wait_ticks(20);
    send_8n1(8'h5A);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h5A || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o} !== 4'b1000) begin
      failures++;
      $display("FAIL after_reset_5a: data=%h flags=%b required data=5a flags=1000", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o});
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int c;
    send_8n1(8'h11);
    send_8n1(8'h22);
    @(negedge clk_i);
    checks++;
    if (rx_data_o !== 8'h11 || {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o} !== 5'b10010) begin
      failures++;
      $display("FAIL overrun_noack: data=%h flags=%b required data=11 flags=10010", rx_data_o,
               {rx_valid_o, parity_err_o, frame_err_o, overrun_err_o, busy_o});
    end
    rx_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (rx_valid_o !== 1'b0 || overrun_err_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: valid=%b overrun=%b required 0 0", rx_valid_o, overrun_err_o);
    end
    @(negedge clk_i);
    rx_ack_i = 1'b0;
    fork
      begin
        send_8n1(8'h11);
        send_8n1(8'h22);
      end
      begin
        c = 0;
        while (rx_valid_o !== 1'b1 && c < 2000) begin
          @(negedge clk_i);
          c++;
        end
        wait_state(ST_STOP1, 2000, "second_stop1");
        // the stop-bit sample is the 16th tick after STOP1 is entered
        wait_ticks(15);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rx_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (rx_data_o !== 8'h22 || rx_valid_o !== 1'b1 || overrun_err_o !== 1'b0) begin
          failures++;
          $display("FAIL ack_at_completion: data=%h valid=%b overrun=%b required data=22 valid=1 overrun=0",
                   rx_data_o, rx_valid_o, overrun_err_o);
        end
        @(negedge clk_i);
        rx_ack_i = 1'b0;
      end
    join
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
